mips_mc_controller: RTL and testbench
=====================================

// Module: mips_mc_controller
// PURPOSE
//  Multicycle control FSM that sequences the shared ALU, memory port, IR, PC and register file.
//  Decodes opcode/funct, drives mips_pkg::alu_op_e, datapath muxes and write enables one state per cycle.
//  Supports lw, sw, R-type (add/sub/and/or/slt), beq, addi and j.
//  Stalls on a req/ready memory handshake.
// PARAMETERS
//  MEM_TIMEOUT  16  max wait cycles per memory access before HALT; 0 disables the timeout
// PORTS
//  clk_i          in   1   clock; all state updates on the rising edge
//  rst_i          in   1   reset, synchronous to clk_i, active-high
//  opcode_i       in   6   IR[31:26]
//  funct_i        in   6   IR[5:0]
//  alu_zero_i     in   1   ALU flag; high when the ALU result is NONZERO
//  mem_ready_i    in   1   memory completes the current access this cycle
//  mem_req_o      out  1   memory access request
//  mem_write_o    out  1   access is a write (valid only with mem_req_o)
//  iord_o         out  1   address source: 0=PC, 1=ALUOut
//  ir_write_o     out  1   load IR
//  pc_write_o     out  1   load PC
//  pc_src_o       out  2   00=ALU result, 01=ALUOut, 10=jump target
//  alu_src_a_o    out  1   0=PC, 1=regA
//  alu_src_b_o    out  2   00=regB, 01=const 4, 10=signext imm, 11=signext imm<<2
//  alu_op_o       out  3   mips_pkg::alu_op_e
//  reg_write_o    out  1   register-file write enable
//  reg_dst_o      out  1   0=rt, 1=rd
//  mem_to_reg_o   out  1   0=ALUOut, 1=MDR
//  halted_o       out  1   FSM is in HALT (sticky until reset)
//  illegal_o      out  1   HALT cause: illegal opcode/funct
//  timeout_o      out  1   HALT cause: memory timeout
// BEHAVIOUR
//  - Outputs are combinational from state (+ mem_ready_i/alu_zero_i where noted).
//  - Every unnamed output is 0; mux selects default to 0 and alu_op_o to ALU_ADD.
//  - Reset: rst_i high at an edge -> state=FETCH, wait counter=0, cause flags=0.
//  - While rst_i is high, all enables and mem_req_o are forced 0; this applies mid-access too, and the pending access is dropped.
//  - FETCH: mem_req=1, iord=0, src_a=0, src_b=01, ADD.
//    - If mem_ready_i: ir_write=1, pc_write=1, pc_src=00, go to DECODE.
//  - DECODE: src_a=0, src_b=11, ADD (branch target into ALUOut). Next state by opcode:
//    - 0x23/0x2B -> MEMADR; 0x00 -> EXECUTE; 0x04 -> BRANCH; 0x08 -> ADDIEX; 0x02 -> JUMP.
//    - Any other opcode -> HALT with illegal_o=1.
//  - MEMADR: src_a=1, src_b=10, ADD; lw -> MEMRD, sw -> MEMWR.
//  - MEMRD: mem_req=1, iord=1; on ready -> MEMWB.
//  - MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0 -> FETCH.
//  - MEMWR: mem_req=1, mem_write=1, iord=1; on ready -> FETCH.
//  - EXECUTE: src_a=1, src_b=00; alu_op set by funct:
//    - 0x20 ADD, 0x22 SUB, 0x24 AND, 0x25 OR, 0x2A SLT.
//    - Valid funct -> ALUWB; any other funct -> HALT with illegal_o=1.
//  - ALUWB: reg_write=1, reg_dst=1, mem_to_reg=0 -> FETCH.
//  - BRANCH: src_a=1, src_b=00, SUB, pc_src=01; pc_write=~alu_zero_i (taken when equal) -> FETCH.
//  - ADDIEX: src_a=1, src_b=10, ADD -> ADDIWB: reg_write=1, reg_dst=0 -> FETCH.
//  - JUMP: pc_src=10, pc_write=1 -> FETCH.
//  - HALT: all enables 0, mem_req 0, halted_o=1; exit only via reset.
//  - Memory wait: the wait counter clears on entry to FETCH/MEMRD/MEMWR and increments each cycle without ready.
//    - When count==MEM_TIMEOUT-1 and no ready -> HALT with timeout_o=1.
//    - Ready on that same cycle wins; the access completes normally.
//  - Latency without wait states: R/addi 4, lw 5, sw 4, beq 3, j 3 cycles.
//  - mem_ready_i is ignored when mem_req_o=0.
// CONFIGURATION
//  MIPS_MC_BNE_EN defined: opcode 0x05 (bne) -> BRANCH with pc_write=alu_zero_i.
//  MIPS_MC_BNE_EN undefined: opcode 0x05 is illegal -> HALT with illegal_o=1.
// STRUCTURE
//  mips_pkg: existing alu_op_e, plus:
//    - mc_state_e (FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECUTE, ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP, HALT);
//    - opcode_e and funct_e constants;
//    - alu_src_b_e and pc_src_e enums.
//  One sub-module: mips_alu_decoder (combinational funct/state -> alu_op_e).
//  The state register, wait counter and output logic stay in this module.
// TESTING
//  - Reset mid-MEMRD (rst_i for 1 cycle) -> next cycle FETCH with mem_req=1, no reg_write.
//  - add (op 0x00, funct 0x20), ready every cycle -> states F,D,EX,WB; alu_op=ADD in EX; reg_write and reg_dst=1 in cycle 4.
//  - lw with 3 wait cycles on MEMRD -> mem_req held 4 cycles, then MEMWB with mem_to_reg=1; total 8 cycles.
//  - beq with alu_zero_i=0 -> pc_write=1, pc_src=01; with alu_zero_i=1 -> pc_write=0.
//  - Opcode 0x3F -> HALT, illegal_o=1, halted_o=1, all enables 0 until rst_i.
//  - MEM_TIMEOUT=4, no ready in FETCH -> HALT with timeout_o=1 after exactly 4 request cycles.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared types for the multicycle MIPS controller: ALU operations, FSM states,
// opcode/funct constants and datapath mux selects.
package mips_pkg;

  typedef enum logic [2:0] {
    ALU_AND = 3'b000,
    ALU_OR  = 3'b001,
    ALU_ADD = 3'b010,
    ALU_SUB = 3'b110,
    ALU_SLT = 3'b111
  } alu_op_e;

  typedef enum logic [3:0] {
    FETCH,
    DECODE,
    MEMADR,
    MEMRD,
    MEMWB,
    MEMWR,
    EXECUTE,
    ALUWB,
    BRANCH,
    ADDIEX,
    ADDIWB,
    JUMP,
    HALT
  } mc_state_e;

  typedef enum logic [5:0] {
    OP_RTYPE = 6'h00,
    OP_J     = 6'h02,
    OP_BEQ   = 6'h04,
    OP_BNE   = 6'h05,
    OP_ADDI  = 6'h08,
    OP_LW    = 6'h23,
    OP_SW    = 6'h2B
  } opcode_e;

  typedef enum logic [5:0] {
    FN_ADD = 6'h20,
    FN_SUB = 6'h22,
    FN_AND = 6'h24,
    FN_OR  = 6'h25,
    FN_SLT = 6'h2A
  } funct_e;

  typedef enum logic [1:0] {
    SRCB_REG     = 2'b00,
    SRCB_FOUR    = 2'b01,
    SRCB_IMM     = 2'b10,
    SRCB_IMM_SH2 = 2'b11
  } alu_src_b_e;

  typedef enum logic [1:0] {
    PCSRC_ALU    = 2'b00,
    PCSRC_ALUOUT = 2'b01,
    PCSRC_JUMP   = 2'b10
  } pc_src_e;

  // States that hold a memory request open and are subject to the wait counter.
  function automatic logic is_mem_state(mc_state_e s);
    return (s == FETCH) || (s == MEMRD) || (s == MEMWR);
  endfunction

endpackage

// File: rtl/mips_alu_decoder.sv
// Combinational ALU control: selects the ALU operation from the controller
// state and, in EXECUTE, from the R-type funct field.
module mips_alu_decoder
  import mips_pkg::*;
(
  input  mc_state_e   state_i,
  input  logic [5:0]  funct_i,
  output alu_op_e     alu_op_o,
  output logic        funct_valid_o
);

  alu_op_e funct_op;

  // NOTE: every variable written here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    funct_op      = ALU_ADD;
    funct_valid_o = 1'b1;
    case (funct_i)
      FN_ADD:  funct_op = ALU_ADD;
      FN_SUB:  funct_op = ALU_SUB;
      FN_AND:  funct_op = ALU_AND;
      FN_OR:   funct_op = ALU_OR;
      FN_SLT:  funct_op = ALU_SLT;
      default: funct_valid_o = 1'b0;
    endcase
  end

  always_comb begin
    alu_op_o = ALU_ADD;
    case (state_i)
      EXECUTE: alu_op_o = funct_op;
      BRANCH:  alu_op_o = ALU_SUB;
      default: alu_op_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mips_mc_controller.sv
// Multicycle MIPS control FSM with req/ready memory stalls and a wait timeout.
// Define MIPS_MC_BNE_EN to decode opcode 0x05 (bne); otherwise it halts as illegal.
module mips_mc_controller
  import mips_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [5:0]  opcode_i,
  input  logic [5:0]  funct_i,
  input  logic        alu_zero_i,
  input  logic        mem_ready_i,
  output logic        mem_req_o,
  output logic        mem_write_o,
  output logic        iord_o,
  output logic        ir_write_o,
  output logic        pc_write_o,
  output logic [1:0]  pc_src_o,
  output logic        alu_src_a_o,
  output logic [1:0]  alu_src_b_o,
  output alu_op_e     alu_op_o,
  output logic        reg_write_o,
  output logic        reg_dst_o,
  output logic        mem_to_reg_o,
  output logic        halted_o,
  output logic        illegal_o,
  output logic        timeout_o
);

  localparam int unsigned CNT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] LAST_WAIT =
    (MEM_TIMEOUT == 0) ? '0 : CNT_W'(MEM_TIMEOUT - 1);

  mc_state_e        state_q, state_d;
  logic [CNT_W-1:0] wait_q, wait_d;
  logic             illegal_q, illegal_d;
  logic             timeout_q, timeout_d;
  logic             funct_valid;
  logic             wait_expired;

  mips_alu_decoder u_alu_decoder (
    .state_i       (state_q),
    .funct_i       (funct_i),
    .alu_op_o      (alu_op_o),
    .funct_valid_o (funct_valid)
  );

  assign wait_expired = (MEM_TIMEOUT != 0) && (wait_q == LAST_WAIT);

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= FETCH;
      wait_q    <= '0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      illegal_q <= illegal_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    wait_d    = '0;
    illegal_d = illegal_q;
    timeout_d = timeout_q;

    case (state_q)
      FETCH:   if (mem_ready_i) state_d = DECODE;
      DECODE: begin
        case (opcode_i)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_RTYPE:     state_d = EXECUTE;
`ifdef MIPS_MC_BNE_EN
          OP_BEQ, OP_BNE: state_d = BRANCH;
`else
          OP_BEQ:       state_d = BRANCH;
`endif
          OP_ADDI:      state_d = ADDIEX;
          OP_J:         state_d = JUMP;
          default: begin
            state_d   = HALT;
            illegal_d = 1'b1;
          end
        endcase
      end
      MEMADR:  state_d = (opcode_i == OP_LW) ? MEMRD : MEMWR;
      MEMRD:   if (mem_ready_i) state_d = MEMWB;
      MEMWB:   state_d = FETCH;
      MEMWR:   if (mem_ready_i) state_d = FETCH;
      EXECUTE: begin
        if (funct_valid) begin
          state_d = ALUWB;
        end else begin
          state_d   = HALT;
          illegal_d = 1'b1;
        end
      end
      ALUWB:   state_d = FETCH;
      BRANCH:  state_d = FETCH;
      ADDIEX:  state_d = ADDIWB;
      ADDIWB:  state_d = FETCH;
      JUMP:    state_d = FETCH;
      HALT:    state_d = HALT;
      default: state_d = HALT;
    endcase

    // Stalled access: count the wait, or give up once the budget is spent.
    // A ready on the last allowed cycle is handled above and wins.
    if (is_mem_state(state_q) && !mem_ready_i) begin
      if (wait_expired) begin
        state_d   = HALT;
        timeout_d = 1'b1;
      end else begin
        wait_d = wait_q + CNT_W'(1);
      end
    end
  end

  always_comb begin
    mem_req_o    = 1'b0;
    mem_write_o  = 1'b0;
    iord_o       = 1'b0;
    ir_write_o   = 1'b0;
    pc_write_o   = 1'b0;
    pc_src_o     = PCSRC_ALU;
    alu_src_a_o  = 1'b0;
    alu_src_b_o  = SRCB_REG;
    reg_write_o  = 1'b0;
    reg_dst_o    = 1'b0;
    mem_to_reg_o = 1'b0;

    case (state_q)
      FETCH: begin
        mem_req_o   = 1'b1;
        alu_src_b_o = SRCB_FOUR;
        ir_write_o  = mem_ready_i;
        pc_write_o  = mem_ready_i;
      end
      DECODE:  alu_src_b_o = SRCB_IMM_SH2;
      MEMADR: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = SRCB_IMM;
      end
      MEMRD: begin
        mem_req_o = 1'b1;
        iord_o    = 1'b1;
      end
      MEMWB: begin
        reg_write_o  = 1'b1;
        mem_to_reg_o = 1'b1;
      end
      MEMWR: begin
        mem_req_o   = 1'b1;
        mem_write_o = 1'b1;
        iord_o      = 1'b1;
      end
      EXECUTE: alu_src_a_o = 1'b1;
      ALUWB: begin
        reg_write_o = 1'b1;
        reg_dst_o   = 1'b1;
      end
      BRANCH: begin
        alu_src_a_o = 1'b1;
        pc_src_o    = PCSRC_ALUOUT;
        // alu_zero_i is high on a nonzero difference, so beq takes on low.
`ifdef MIPS_MC_BNE_EN
        pc_write_o  = (opcode_i == OP_BNE) ? alu_zero_i : ~alu_zero_i;
`else
        pc_write_o  = ~alu_zero_i;
`endif
      end
      ADDIEX: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = SRCB_IMM;
      end
      ADDIWB:  reg_write_o = 1'b1;
      JUMP: begin
        pc_src_o   = PCSRC_JUMP;
        pc_write_o = 1'b1;
      end
      default: ;
    endcase

    if (rst_i) begin
      mem_req_o   = 1'b0;
      mem_write_o = 1'b0;
      ir_write_o  = 1'b0;
      pc_write_o  = 1'b0;
      reg_write_o = 1'b0;
    end
  end

  assign halted_o  = (state_q == HALT);
  assign illegal_o = illegal_q;
  assign timeout_o = timeout_q;

endmodule

// File: tb/tb_mips_mc_controller.sv
// Self-checking bench for mips_mc_controller: directed scenarios plus a random
// instruction stream checked cycle by cycle against a per-instruction control model.
module tb_mips_mc_controller;
  import mips_pkg::*;

  typedef struct packed {
    logic       mem_req;
    logic       mem_write;
    logic       iord;
    logic       ir_write;
    logic       pc_write;
    logic [1:0] pc_src;
    logic       src_a;
    logic [1:0] src_b;
    logic [2:0] alu_op;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       halted;
    logic       illegal;
    logic       timeout;
  } ctl_t;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic [5:0] opcode_i;
  logic [5:0] funct_i;
  logic       alu_zero_i;
  logic       mem_ready_i;
  logic       mem_req_o, mem_write_o, iord_o, ir_write_o, pc_write_o;
  logic [1:0] pc_src_o, alu_src_b_o;
  logic       alu_src_a_o;
  alu_op_e    alu_op_o;
  logic       reg_write_o, reg_dst_o, mem_to_reg_o;
  logic       halted_o, illegal_o, timeout_o;

  int vectors     = 0;
  int miscompares = 0;

  mips_mc_controller #(.MEM_TIMEOUT(4)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .opcode_i     (opcode_i),
    .funct_i      (funct_i),
    .alu_zero_i   (alu_zero_i),
    .mem_ready_i  (mem_ready_i),
    .mem_req_o    (mem_req_o),
    .mem_write_o  (mem_write_o),
    .iord_o       (iord_o),
    .ir_write_o   (ir_write_o),
    .pc_write_o   (pc_write_o),
    .pc_src_o     (pc_src_o),
    .alu_src_a_o  (alu_src_a_o),
    .alu_src_b_o  (alu_src_b_o),
    .alu_op_o     (alu_op_o),
    .reg_write_o  (reg_write_o),
    .reg_dst_o    (reg_dst_o),
    .mem_to_reg_o (mem_to_reg_o),
    .halted_o     (halted_o),
    .illegal_o    (illegal_o),
    .timeout_o    (timeout_o)
  );

  always #5 clk_i = ~clk_i;

  // ---------------- reference model: control word per instruction phase
  function automatic ctl_t idle();
    ctl_t c = '0;
    c.alu_op = ALU_ADD;
    return c;
  endfunction

  function automatic logic [2:0] alu_for(logic [5:0] fn);
    case (fn)
      6'h20:   return ALU_ADD;
      6'h22:   return ALU_SUB;
      6'h24:   return ALU_AND;
      6'h25:   return ALU_OR;
      6'h2A:   return ALU_SLT;
      default: return ALU_ADD;
    endcase
  endfunction

  function automatic bit funct_ok(logic [5:0] fn);
    return fn inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
  endfunction

  function automatic bit opcode_ok(logic [5:0] op);
`ifdef MIPS_MC_BNE_EN
    return op inside {6'h00, 6'h02, 6'h04, 6'h05, 6'h08, 6'h23, 6'h2B};
`else
    return op inside {6'h00, 6'h02, 6'h04, 6'h08, 6'h23, 6'h2B};
`endif
  endfunction

  function automatic ctl_t f_fetch(logic rdy);
    ctl_t c = idle();
    c.mem_req = 1'b1; c.src_b = 2'b01; c.ir_write = rdy; c.pc_write = rdy;
    return c;
  endfunction
  function automatic ctl_t f_decode();
    ctl_t c = idle(); c.src_b = 2'b11; return c;
  endfunction
  function automatic ctl_t f_memadr();
    ctl_t c = idle(); c.src_a = 1'b1; c.src_b = 2'b10; return c;
  endfunction
  function automatic ctl_t f_memacc(logic wr);
    ctl_t c = idle(); c.mem_req = 1'b1; c.mem_write = wr; c.iord = 1'b1; return c;
  endfunction
  function automatic ctl_t f_memwb();
    ctl_t c = idle(); c.reg_write = 1'b1; c.mem_to_reg = 1'b1; return c;
  endfunction
  function automatic ctl_t f_exec(logic [5:0] fn);
    ctl_t c = idle(); c.src_a = 1'b1; c.alu_op = alu_for(fn); return c;
  endfunction
  function automatic ctl_t f_aluwb();
    ctl_t c = idle(); c.reg_write = 1'b1; c.reg_dst = 1'b1; return c;
  endfunction
  function automatic ctl_t f_branch(logic [5:0] op, logic zero);
    ctl_t c = idle();
    c.src_a = 1'b1; c.alu_op = ALU_SUB; c.pc_src = 2'b01;
    c.pc_write = (op == 6'h05) ? zero : ~zero;
    return c;
  endfunction
  function automatic ctl_t f_addiex();
    ctl_t c = idle(); c.src_a = 1'b1; c.src_b = 2'b10; return c;
  endfunction
  function automatic ctl_t f_addiwb();
    ctl_t c = idle(); c.reg_write = 1'b1; return c;
  endfunction
  function automatic ctl_t f_jump();
    ctl_t c = idle(); c.pc_src = 2'b10; c.pc_write = 1'b1; return c;
  endfunction
  function automatic ctl_t f_halt(logic ill, logic to);
    ctl_t c = idle(); c.halted = 1'b1; c.illegal = ill; c.timeout = to; return c;
  endfunction

  // ---------------- one clock cycle: drive at negedge, sample 1 time unit later
  task automatic step(input ctl_t exp, input logic rdy, input logic zero,
                      input logic rst, input string tag);
    ctl_t e;
    ctl_t obs;
    @(negedge clk_i);
    mem_ready_i = rdy;
    alu_zero_i  = zero;
    rst_i       = rst;
    #1;
    e = exp;
    if (rst) begin
      e.mem_req = 1'b0; e.mem_write = 1'b0; e.ir_write = 1'b0;
      e.pc_write = 1'b0; e.reg_write = 1'b0;
    end
    obs = '{mem_req_o, mem_write_o, iord_o, ir_write_o, pc_write_o, pc_src_o,
            alu_src_a_o, alu_src_b_o, alu_op_o, reg_write_o, reg_dst_o,
            mem_to_reg_o, halted_o, illegal_o, timeout_o};
    vectors++;
    assert (obs === e) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h (op=%h fn=%h)", tag, obs, e, opcode_i, funct_i);
    end
  endtask

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic halt_and_reset(input logic ill, input logic to, input string tag);
    for (int i = 0; i < 3; i++) step(f_halt(ill, to), rbit(), rbit(), 1'b0, tag);
    step(f_halt(ill, to), 1'b1, rbit(), 1'b1, {tag, "_rst"});
  endtask

  // One full instruction; fw/mw are wait cycles in FETCH and in the memory access.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int fw,
                           input int mw, input logic zero, input string tag);
    opcode_i = op;
    funct_i  = fn;
    for (int i = 0; i < fw; i++) step(f_fetch(1'b0), 1'b0, rbit(), 1'b0, {tag, "_fetchwait"});
    step(f_fetch(1'b1), 1'b1, rbit(), 1'b0, {tag, "_fetch"});
    step(f_decode(), rbit(), rbit(), 1'b0, {tag, "_decode"});
    if (!opcode_ok(op)) begin
      halt_and_reset(1'b1, 1'b0, {tag, "_illop"});
    end else begin
      case (op)
        6'h23, 6'h2B: begin
          step(f_memadr(), rbit(), rbit(), 1'b0, {tag, "_memadr"});
          for (int i = 0; i < mw; i++)
            step(f_memacc(op == 6'h2B), 1'b0, rbit(), 1'b0, {tag, "_memwait"});
          step(f_memacc(op == 6'h2B), 1'b1, rbit(), 1'b0, {tag, "_memacc"});
          if (op == 6'h23) step(f_memwb(), rbit(), rbit(), 1'b0, {tag, "_memwb"});
        end
        6'h00: begin
          step(f_exec(fn), rbit(), rbit(), 1'b0, {tag, "_exec"});
          if (funct_ok(fn)) step(f_aluwb(), rbit(), rbit(), 1'b0, {tag, "_aluwb"});
          else halt_and_reset(1'b1, 1'b0, {tag, "_illfn"});
        end
        6'h04, 6'h05: step(f_branch(op, zero), rbit(), zero, 1'b0, {tag, "_branch"});
        6'h08: begin
          step(f_addiex(), rbit(), rbit(), 1'b0, {tag, "_addiex"});
          step(f_addiwb(), rbit(), rbit(), 1'b0, {tag, "_addiwb"});
        end
        default: step(f_jump(), rbit(), rbit(), 1'b0, {tag, "_jump"});
      endcase
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, vectors=%0d", vectors);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] op;
    logic [5:0] fn;
    logic [5:0] legal_ops [6];
    logic [5:0] legal_fns [5];
    legal_ops = '{6'h00, 6'h02, 6'h04, 6'h08, 6'h23, 6'h2B};
    legal_fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};

    rst_i = 1'b1; mem_ready_i = 1'b0; alu_zero_i = 1'b0;
    opcode_i = 6'h00; funct_i = 6'h20;
    repeat (2) @(posedge clk_i);

    // Reset holds FETCH with request and enables suppressed even with ready high.
    step(f_fetch(1'b1), 1'b1, 1'b0, 1'b1, "reset_hold");

    run_instr(6'h00, 6'h20, 0, 0, 1'b0, "add");
    run_instr(6'h00, 6'h22, 0, 0, 1'b0, "sub");
    run_instr(6'h23, 6'h00, 0, 3, 1'b0, "lw_wait3");
    run_instr(6'h2B, 6'h00, 3, 1, 1'b0, "sw_fetchwait3");
    run_instr(6'h04, 6'h00, 0, 0, 1'b0, "beq_taken");
    run_instr(6'h04, 6'h00, 0, 0, 1'b1, "beq_not_taken");
    run_instr(6'h08, 6'h00, 0, 0, 1'b0, "addi");
    run_instr(6'h02, 6'h00, 0, 0, 1'b0, "j");
    run_instr(6'h05, 6'h00, 0, 0, 1'b1, "bne");

    // Reset while MEMRD is stalled: access dropped, FETCH follows.
    opcode_i = 6'h23;
    step(f_fetch(1'b1), 1'b1, 1'b0, 1'b0, "midrd_fetch");
    step(f_decode(), 1'b0, 1'b0, 1'b0, "midrd_decode");
    step(f_memadr(), 1'b0, 1'b0, 1'b0, "midrd_memadr");
    step(f_memacc(1'b0), 1'b0, 1'b0, 1'b0, "midrd_wait");
    step(f_memacc(1'b0), 1'b1, 1'b0, 1'b1, "midrd_rst");
    step(f_fetch(1'b0), 1'b0, 1'b0, 1'b0, "midrd_after");
    step(f_fetch(1'b1), 1'b1, 1'b0, 1'b0, "midrd_after_rdy");
    step(f_decode(), 1'b0, 1'b0, 1'b0, "midrd_decode2");
    step(f_memadr(), 1'b0, 1'b0, 1'b0, "midrd_memadr2");
    step(f_memacc(1'b0), 1'b1, 1'b0, 1'b0, "midrd_memrd2");
    step(f_memwb(), 1'b0, 1'b0, 1'b0, "midrd_memwb2");

    run_instr(6'h3F, 6'h00, 0, 0, 1'b0, "illegal_3f");
    run_instr(6'h00, 6'h21, 0, 0, 1'b0, "bad_funct");

    // Four fetch cycles with no ready exhaust the budget.
    for (int i = 0; i < 4; i++) step(f_fetch(1'b0), 1'b0, 1'b0, 1'b0, "fetch_to_wait");
    halt_and_reset(1'b0, 1'b1, "fetch_timeout");

    // Same budget on a store.
    opcode_i = 6'h2B;
    step(f_fetch(1'b1), 1'b1, 1'b0, 1'b0, "sw_to_fetch");
    step(f_decode(), 1'b0, 1'b0, 1'b0, "sw_to_decode");
    step(f_memadr(), 1'b0, 1'b0, 1'b0, "sw_to_memadr");
    for (int i = 0; i < 4; i++) step(f_memacc(1'b1), 1'b0, 1'b0, 1'b0, "sw_to_wait");
    halt_and_reset(1'b0, 1'b1, "memwr_timeout");

    for (int n = 0; n < 60; n++) begin
      int kind;
      kind = $urandom_range(0, 9);
      if (kind < 7) begin
        op = legal_ops[$urandom_range(0, 5)];
        fn = legal_fns[$urandom_range(0, 4)];
      end else if (kind < 9) begin
        op = 6'h00;
        do fn = 6'($urandom_range(0, 63)); while (funct_ok(fn));
      end else begin
        do op = 6'($urandom_range(0, 63)); while (opcode_ok(op));
        fn = 6'($urandom_range(0, 63));
      end
      run_instr(op, fn, $urandom_range(0, 3), $urandom_range(0, 3), rbit(), "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
